kmul_feed: RTL and testbench

Streaming coefficient multiplier front-end that sits directly upstream of the K2RED reducer (q = 3329). It accepts operand pairs on a valid/ready input and drives the 24-bit product into the reducer's non-stallable pipeline. It tracks each in-flight product with a latency-matched valid/tag pipe and captures the reduced 12-bit result into an output FIFO. Credit accounting guarantees that the non-stallable reducer can never overflow the FIFO.

---
 rtl/kmul_feed.sv | 140 ++++++++++++++
 tb/tb_kmul_feed.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kmul_feed.sv
// Multiplier front-end for the K2RED reducer: registers a*b into the reducer, tracks
// in-flight results with a latency-matched valid/tag pipe and buffers them in a credit-guarded FWFT FIFO.
// Optional operand range check is enabled by defining KMUL_RANGE_CHK_EN.
module kmul_feed #(
  parameter int CW      = 12,
  parameter int PW      = 24,
  parameter int RED_LAT = 5,
  parameter int DEPTH   = 8,
  parameter int TAG_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_a,
  input  logic [CW-1:0]    in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [PW-1:0]    red_c,
  input  logic [CW-1:0]    red_cred,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
`ifdef KMUL_RANGE_CHK_EN
  ,
  output logic             err
`endif
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam logic [CNTW-1:0] FULL_V  = CNTW'(DEPTH);
  localparam logic [CNTW:0]   DEPTH_V = (CNTW+1)'(DEPTH);

  logic             ready_en;
  logic             accept;
  logic [PW-1:0]    prod;
  logic [PW-1:0]    prod_next;

  logic [RED_LAT:0] pv;
  logic [TAG_W-1:0] pt [RED_LAT+1];
  logic             fifo_wr;

  logic [CNTW-1:0]  inflight;
  logic [CNTW-1:0]  cnt;
  logic [CNTW:0]    credit_used;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop;
  logic [CW+TAG_W-1:0] mem [DEPTH];

  assign accept = in_valid & in_ready;
  assign prod   = {{(PW-CW){1'b0}}, in_a} * {{(PW-CW){1'b0}}, in_b};

`ifdef KMUL_RANGE_CHK_EN
  localparam logic [CW-1:0] QV = CW'(3329);
  logic range_bad;

  assign range_bad = (in_a >= QV) | (in_b >= QV);
  assign prod_next = range_bad ? '0 : prod;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    err <= 1'b0;
    else if (accept & range_bad) err <= 1'b1;
  end
`else
  assign prod_next = prod;
`endif

  // Holds in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_en <= 1'b0;
    else      ready_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) red_c <= '0;
    else      red_c <= accept ? prod_next : '0;
  end

  // Stage 0 lines up with red_c; the last stage lines up with red_cred.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv <= '0;
      for (int i = 0; i <= RED_LAT; i++) pt[i] <= '0;
    end else begin
      pv    <= {pv[RED_LAT-1:0], accept};
      pt[0] <= in_tag;
      for (int i = 1; i <= RED_LAT; i++) pt[i] <= pt[i-1];
    end
  end

  assign fifo_wr = pv[RED_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= '0;
    end else begin
      unique case ({accept, fifo_wr})
        2'b10:   inflight <= inflight + CNTW'(1);
        2'b01:   inflight <= inflight - CNTW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign out_valid = (cnt != '0);
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr] <= {red_cred, pt[RED_LAT]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      unique case ({fifo_wr, pop})
        2'b10:   cnt <= cnt + CNTW'(1);
        2'b01:   cnt <= cnt - CNTW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign {out_data, out_tag} = mem[rd_ptr];

  // Every accepted op already owns a FIFO slot, so the reducer can never overrun the buffer.
  assign credit_used = {1'b0, cnt} + {1'b0, inflight};
  assign in_ready    = ready_en & (credit_used < DEPTH_V);
  assign busy        = (inflight != '0) | (cnt != '0);

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst) !(fifo_wr && (cnt == FULL_V)));

endmodule

// File: tb/tb_kmul_feed.sv
// Bench for kmul_feed with a behavioural K2RED model (169*c mod 3329, fixed latency)
// and a scoreboard of expected {data, tag} pushed at each accept and popped at each delivery.
module tb_kmul_feed;

  localparam int CW      = 12;
  localparam int PW      = 24;
  localparam int RED_LAT = 5;
  localparam int DEPTH   = 8;
  localparam int TAG_W   = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [CW-1:0]    in_a = '0;
  logic [CW-1:0]    in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic [PW-1:0]    red_c;
  logic [CW-1:0]    red_cred;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CW-1:0]    out_data;
  logic [TAG_W-1:0] out_tag;
  logic             busy;
`ifdef KMUL_RANGE_CHK_EN
  logic             err;
`endif

  kmul_feed #(.CW(CW), .PW(PW), .RED_LAT(RED_LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .red_c(red_c), .red_cred(red_cred),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .busy(busy)
`ifdef KMUL_RANGE_CHK_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] reduce(input logic [PW-1:0] c);
    longint unsigned t;
    t = 64'(c) * 64'd169;
    return CW'(t % 64'd3329);
  endfunction

  function automatic logic [CW-1:0] model(input logic [CW-1:0] a, input logic [CW-1:0] b);
    longint unsigned p;
    p = 64'(a) * 64'(b);
`ifdef KMUL_RANGE_CHK_EN
    if (a >= 12'd3329 || b >= 12'd3329) p = 0;
`endif
    return CW'((p * 64'd169) % 64'd3329);
  endfunction

  // Reducer stand-in: non-stallable, RED_LAT registers from red_c to red_cred.
  logic [CW-1:0] rpipe [RED_LAT];
  always @(posedge clk) begin
    rpipe[0] <= reduce(red_c);
    for (int k = 1; k < RED_LAT; k++) rpipe[k] <= rpipe[k-1];
  end
  assign red_cred = rpipe[RED_LAT-1];

  typedef struct {
    logic [CW-1:0]    data;
    logic [TAG_W-1:0] tag;
  } exp_t;

  typedef struct {
    logic [CW-1:0]    a;
    logic [CW-1:0]    b;
    logic [TAG_W-1:0] tag;
    logic [CW-1:0]    exp_data;
  } vec_t;

  exp_t          sb[$];
  logic [CW-1:0] cur_exp = '0;
  int            n_cmp = 0;
  int            n_err = 0;
  int            n_acc = 0;
  int            n_pop = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshakes are sampled mid-cycle, one half-period before the edge that completes them.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (in_valid && in_ready) begin
        sb.push_back('{data: cur_exp, tag: in_tag});
        n_acc++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected result", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("out_data", 32'(out_data), 32'(e.data));
          checkOutput("out_tag", 32'(out_tag), 32'(e.tag));
        end
        n_pop++;
      end
    end
  end

  task automatic applyStimulus(input logic [CW-1:0] a, input logic [CW-1:0] b,
                               input logic [TAG_W-1:0] tag, input logic [CW-1:0] exp);
    int g;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    cur_exp  = exp;
    in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 100) begin
      tick();
      g++;
    end
    if (!in_ready) checkOutput("in_ready timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int g = 0; g < 300; g++) begin
      if (sb.size() == 0 && !busy) break;
      tick();
    end
    checkOutput("drain scoreboard empty", 32'(sb.size()), 32'd0);
    checkOutput("drain busy", 32'(busy), 32'd0);
  endtask

  task automatic setItem(input int i);
    in_a    = CW'(i * 37 + 1);
    in_b    = CW'(i * 101 + 3);
    in_tag  = TAG_W'(8'h50 + i);
    cur_exp = model(in_a, in_b);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[10];
    int   lat;
    int   acc0;
    int   pop0;
    int   idx;

    vecs[0] = '{a: 12'd1,    b: 12'd1,    tag: 8'h11, exp_data: 12'd169};
    vecs[1] = '{a: 12'd3328, b: 12'd3328, tag: 8'h12, exp_data: 12'd169};
    vecs[2] = '{a: 12'd2,    b: 12'd1665, tag: 8'h13, exp_data: 12'd169};
    vecs[3] = '{a: 12'd0,    b: 12'd1234, tag: 8'h14, exp_data: 12'd0};
    vecs[4] = '{a: 12'd3329, b: 12'd5,    tag: 8'h15, exp_data: 12'd0};
    vecs[5] = '{a: 12'd5,    b: 12'd7,    tag: 8'h16, exp_data: 12'd2586};
    vecs[6] = '{a: 12'd100,  b: 12'd200,  tag: 8'h17, exp_data: 12'd1065};
`ifdef KMUL_RANGE_CHK_EN
    vecs[7] = '{a: 12'd4095, b: 12'd4095, tag: 8'h18, exp_data: 12'd0};
`else
    vecs[7] = '{a: 12'd4095, b: 12'd4095, tag: 8'h18, exp_data: 12'd841};
`endif
    vecs[8] = '{a: 12'd3328, b: 12'd1,    tag: 8'h19, exp_data: 12'd3160};
    vecs[9] = '{a: 12'd1,    b: 12'd2,    tag: 8'h1a, exp_data: 12'd338};

    // Reset state
    repeat (3) tick();
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset red_c", 32'(red_c), 32'd0);
    rst = 1'b1;
    tick();
    checkOutput("in_ready after release", 32'(in_ready), 32'd1);
`ifdef KMUL_RANGE_CHK_EN
    checkOutput("err after reset", 32'(err), 32'd0);
`endif

    // Single op latency: out_valid must rise exactly RED_LAT+2 edges after presentation
    out_ready = 1'b1;
    in_a = 12'd1; in_b = 12'd1; in_tag = 8'h11; cur_exp = 12'd169;
    in_valid = 1'b1;
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      tick();
      if (c == 1) in_valid = 1'b0;
      if (out_valid) lat = c;
    end
    checkOutput("single-op latency", 32'(lat), 32'(RED_LAT + 2));
    drain();

    // Back-to-back pair must come out on consecutive cycles
    in_a = 12'd3328; in_b = 12'd3328; in_tag = 8'h21; cur_exp = 12'd169;
    in_valid = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1) begin
        in_a = 12'd2; in_b = 12'd1665; in_tag = 8'h22; cur_exp = 12'd169;
      end
      if (c == 2) in_valid = 1'b0;
      if (c == RED_LAT + 1) checkOutput("b2b out_valid before", 32'(out_valid), 32'd0);
      if (c == RED_LAT + 2) checkOutput("b2b first out_valid", 32'(out_valid), 32'd1);
      if (c == RED_LAT + 3) checkOutput("b2b second out_valid", 32'(out_valid), 32'd1);
    end
    drain();

    // Table of vectors, streamed back to back
    for (int i = 0; i < 10; i++)
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp_data);
    in_valid = 1'b0;
    drain();
`ifdef KMUL_RANGE_CHK_EN
    checkOutput("err sticky after range op", 32'(err), 32'd1);
    repeat (3) tick();
    checkOutput("err still set", 32'(err), 32'd1);
`endif

    // Stalled consumer: only DEPTH ops may be accepted
    out_ready = 1'b0;
    acc0 = n_acc;
    pop0 = n_pop;
    idx  = 0;
    setItem(0);
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (n_acc - acc0 > idx) begin
        idx = n_acc - acc0;
        if (idx < 12) setItem(idx);
        else in_valid = 1'b0;
      end
    end
    checkOutput("accepted while stalled", 32'(n_acc - acc0), 32'(DEPTH));
    checkOutput("in_ready while full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 100 && idx < 12; c++) begin
      tick();
      if (n_acc - acc0 > idx) begin
        idx = n_acc - acc0;
        if (idx < 12) setItem(idx);
      end
    end
    in_valid = 1'b0;
    drain();
    checkOutput("stalled batch delivered", 32'(n_pop - pop0), 32'd12);

    // Accept, FIFO write and pop on the same edge with the FIFO nearly full
    out_ready = 1'b0;
    pop0 = n_pop;
    for (int i = 0; i < 6; i++) begin
      setItem(20 + i);
      applyStimulus(in_a, in_b, in_tag, cur_exp);
    end
    in_valid = 1'b0;
    repeat (10) tick();
    setItem(26);
    applyStimulus(in_a, in_b, in_tag, cur_exp);
    in_valid = 1'b0;
    repeat (RED_LAT) tick();
    setItem(27);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput("in_ready after combo edge", 32'(in_ready), 32'd1);
    checkOutput("busy after combo edge", 32'(busy), 32'd1);
    setItem(28);
    applyStimulus(in_a, in_b, in_tag, cur_exp);
    in_valid = 1'b0;
    checkOutput("in_ready at DEPTH credits", 32'(in_ready), 32'd0);
    drain();
    checkOutput("combo batch delivered", 32'(n_pop - pop0), 32'd9);

    // Reset with 3 ops in flight and 2 buffered
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      setItem(40 + i);
      applyStimulus(in_a, in_b, in_tag, cur_exp);
    end
    in_valid = 1'b0;
    repeat (3) tick();
    checkOutput("pre-reset out_valid", 32'(out_valid), 32'd1);
    checkOutput("pre-reset busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("reset out_valid immediate", 32'(out_valid), 32'd0);
    checkOutput("reset busy immediate", 32'(busy), 32'd0);
    checkOutput("reset in_ready immediate", 32'(in_ready), 32'd0);
    sb.delete();
    tick();
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    checkOutput("in_ready after second release", 32'(in_ready), 32'd1);
    for (int c = 0; c < 10; c++) begin
      checkOutput("no stale out_valid", 32'(out_valid), 32'd0);
      tick();
    end
    checkOutput("busy after stale window", 32'(busy), 32'd0);
`ifdef KMUL_RANGE_CHK_EN
    checkOutput("err cleared by reset", 32'(err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
